// File: rtl/div_pkg.sv
// Shared types and sizes for the sequential restoring divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 16;
  localparam int unsigned CNT_W     = $clog2(DIV_WIDTH);
  localparam int unsigned REM_W     = DIV_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CALC,
    ST_DONE
  } state_e;

endpackage

// File: rtl/trial_subtractor.sv
// Trial subtraction for one restoring step; kept separate so the adder can be swapped.
module trial_subtractor
  import div_pkg::*;
(
  input  logic [REM_W-1:0] r_shift,
  input  logic [REM_W-1:0] d,
  output logic [REM_W-1:0] diff_c,
  output logic             ge_c
);

  // Borrow out of the top bit means the divisor did not fit.
  assign diff_c = r_shift - d;
  assign ge_c   = ~diff_c[REM_W-1];

endmodule

// File: rtl/restoring_divider_16.sv
// Unsigned 16-bit restoring divider, one shift-subtract step per clock, Run/Done handshake.
module restoring_divider_16
  import div_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Run,
  input  logic [DIV_WIDTH-1:0] Dividend,
  input  logic [DIV_WIDTH-1:0] Divisor,
  output logic [DIV_WIDTH-1:0] Quotient,
  output logic [DIV_WIDTH-1:0] Remainder,
  output logic                 Done,
  output logic                 Busy,
  output logic                 DivByZero
);

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] q_q, q_d;
  logic [DIV_WIDTH-1:0] dv_q, dv_d;
  logic [REM_W-1:0]     r_q, r_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] quot_q, quot_d;
  logic [DIV_WIDTH-1:0] rem_q, rem_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 dbz_q, dbz_d;

  logic [REM_W-1:0]     r_shift_c;
  logic [REM_W-1:0]     diff_c;
  logic                 ge_c;
  logic [REM_W-1:0]     r_next_c;
  logic [DIV_WIDTH-1:0] q_next_c;
  logic                 last_step_c;

  // Shift the next dividend bit into R; the dropped top bit is always zero because R < D.
  assign r_shift_c   = REM_W'({r_q, q_q[DIV_WIDTH-1]});
  assign r_next_c    = ge_c ? diff_c : r_shift_c;
  assign q_next_c    = {q_q[DIV_WIDTH-2:0], ge_c};
  assign last_step_c = (cnt_q == CNT_W'(DIV_WIDTH - 1));

  trial_subtractor u_sub (
    .r_shift (r_shift_c),
    .d       ({1'b0, dv_q}),
    .diff_c  (diff_c),
    .ge_c    (ge_c)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (Run) state_d = ST_LOAD;
      ST_LOAD: state_d = (dv_q == '0) ? ST_DONE : ST_CALC;
      ST_CALC: if (last_step_c) state_d = ST_DONE;
      ST_DONE: if (!Run) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Status flags follow the state being entered so they register alongside it.
  always_comb begin
    busy_d = (state_d == ST_LOAD) || (state_d == ST_CALC);
    done_d = (state_d == ST_DONE);
  end

  // Working registers and result capture.
  always_comb begin
    q_d    = q_q;
    dv_d   = dv_q;
    r_d    = r_q;
    cnt_d  = cnt_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (Run) begin
          q_d   = Dividend;
          dv_d  = Divisor;
          r_d   = '0;
          cnt_d = '0;
          dbz_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (dv_q == '0) begin
          quot_d = '1;
          rem_d  = q_q;
          dbz_d  = 1'b1;
        end
      end
      ST_CALC: begin
        r_d   = r_next_c;
        q_d   = q_next_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_step_c) begin
          quot_d = q_next_c;
          rem_d  = r_next_c[DIV_WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      q_q    <= '0;
      dv_q   <= '0;
      r_q    <= '0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      dv_q   <= dv_d;
      r_q    <= r_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      done_q <= done_d;
      busy_q <= busy_d;
      dbz_q  <= dbz_d;
    end
  end

  assign Quotient  = quot_q;
  assign Remainder = rem_q;
  assign Done      = done_q;
  assign Busy      = busy_q;
  assign DivByZero = dbz_q;

endmodule

// File: tb/tb_restoring_divider_16.sv
// Scoreboard bench for restoring_divider_16: driver queues expectations, monitor checks on Done.
module tb_restoring_divider_16;

  logic        Clk;
  logic        Reset;
  logic        Run;
  logic [15:0] Dividend;
  logic [15:0] Divisor;
  logic [15:0] Quotient;
  logic [15:0] Remainder;
  logic        Done;
  logic        Busy;
  logic        DivByZero;

  restoring_divider_16 dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Run       (Run),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .Done      (Done),
    .Busy      (Busy),
    .DivByZero (DivByZero)
  );

  typedef struct {
    logic [15:0] n;
    logic [15:0] d;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    int          done_cyc;
    int          busy_len;
  } exp_t;

  exp_t sb[$];

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
  endtask

  // Monitor: compares each completion against the oldest queued expectation.
  logic        prev_done   = 1'b0;
  int          busy_cnt    = 0;
  int          overlap_cnt = 0;
  int          unstable_cnt = 0;
  logic [15:0] last_q      = '0;
  logic [15:0] last_r      = '0;

  always @(negedge Clk) begin
    if (Busy === 1'b1 && Done === 1'b1) overlap_cnt++;
    if (Busy === 1'b1) begin
      if (Quotient !== last_q || Remainder !== last_r) unstable_cnt++;
    end else begin
      last_q = Quotient;
      last_r = Remainder;
    end
    if (Done === 1'b1 && prev_done === 1'b0) begin
      if (sb.size() == 0) begin
        chk_cnt++;
        $display("FAIL spurious_done: got Done=1 at cycle %0d expected no completion", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient",  32'(Quotient),  32'(e.q));
        check("remainder", 32'(Remainder), 32'(e.r));
        check("divbyzero", 32'(DivByZero), 32'(e.dbz));
        check("latency",   32'(cyc),       32'(e.done_cyc));
        check("busy_len",  32'(busy_cnt),  32'(e.busy_len));
        if (!e.dbz) begin
          check("identity",  32'(Quotient) * 32'(e.d) + 32'(Remainder), 32'(e.n));
          check("rem_lt_d",  32'(Remainder < e.d), 32'd1);
        end
      end
      busy_cnt = 0;
    end else if (Busy !== 1'b1) begin
      busy_cnt = 0;
    end
    if (Busy === 1'b1) busy_cnt++;
    prev_done = (Done === 1'b1);
  end

  // Drive a start and queue what the completion must look like.
  task automatic start_op(input logic [15:0] n, input logic [15:0] d,
                          input logic [15:0] q, input logic [15:0] r, input logic dbz);
    exp_t e;
    int   lat;
    @(negedge Clk);
    lat        = dbz ? 1 : 17;
    Dividend   = n;
    Divisor    = d;
    Run        = 1'b1;
    e.n        = n;
    e.d        = d;
    e.q        = q;
    e.r        = r;
    e.dbz      = dbz;
    e.done_cyc = cyc + 1 + lat;
    e.busy_len = lat;
    sb.push_back(e);
  endtask

  // Wait (bounded) for Done, optionally hold Run, then release back to IDLE.
  task automatic finish_op(input int hold);
    for (int i = 0; i < 40 && Done !== 1'b1; i++) @(negedge Clk);
    check("done_wait", 32'(Done), 32'd1);
    if (hold > 0) begin
      repeat (hold) @(negedge Clk);
      check("hold_done", 32'(Done), 32'd1);
      check("hold_busy", 32'(Busy), 32'd0);
    end
    Run = 1'b0;
    @(negedge Clk);
    check("idle_done", 32'(Done), 32'd0);
  endtask

  task automatic run_op(input logic [15:0] n, input logic [15:0] d,
                        input logic [15:0] q, input logic [15:0] r, input logic dbz, input int hold);
    start_op(n, d, q, r, dbz);
    finish_op(hold);
  endtask

  initial begin
    logic [15:0] rn, rd;
    Reset    = 1'b1;
    Run      = 1'b0;
    Dividend = '0;
    Divisor  = '0;
    repeat (3) @(negedge Clk);
    check("rst_quotient",  32'(Quotient),  32'd0);
    check("rst_remainder", 32'(Remainder), 32'd0);
    check("rst_done",      32'(Done),      32'd0);
    check("rst_busy",      32'(Busy),      32'd0);
    check("rst_dbz",       32'(DivByZero), 32'd0);
    Reset = 1'b0;
    @(negedge Clk);

    // Directed vectors with hand-computed results.
    run_op(16'd100,   16'd7,     16'd14,    16'd2, 1'b0, 20);
    run_op(16'hFFFF,  16'd1,     16'hFFFF,  16'd0, 1'b0, 0);
    run_op(16'hFFFF,  16'hFFFF,  16'd1,     16'd0, 1'b0, 0);
    run_op(16'd3,     16'd10,    16'd0,     16'd3, 1'b0, 0);
    run_op(16'd0,     16'd5,     16'd0,     16'd0, 1'b0, 0);
    run_op(16'd5,     16'd0,     16'hFFFF,  16'd5, 1'b1, 2);
    run_op(16'd9,     16'd3,     16'd3,     16'd0, 1'b0, 0);

    // Reset in the middle of CALC, with Run still high on the reset edge.
    start_op(16'd1000, 16'd9, 16'd111, 16'd1, 1'b0);
    repeat (8) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check("midrst_quotient",  32'(Quotient),  32'd0);
    check("midrst_remainder", 32'(Remainder), 32'd0);
    check("midrst_done",      32'(Done),      32'd0);
    check("midrst_busy",      32'(Busy),      32'd0);
    check("midrst_dbz",       32'(DivByZero), 32'd0);
    sb.delete();
    Reset = 1'b0;
    Run   = 1'b0;
    @(negedge Clk);
    check("post_rst_busy", 32'(Busy), 32'd0);
    check("post_rst_done", 32'(Done), 32'd0);

    // Same divide again, with operands scrambled while it runs.
    start_op(16'd1000, 16'd9, 16'd111, 16'd1, 1'b0);
    repeat (5) @(negedge Clk);
    Dividend = 16'd7;
    Divisor  = 16'd2;
    finish_op(0);

    // Random sweep against a reference computed with / and %.
    for (int i = 0; i < 1500; i++) begin
      rn = 16'($urandom);
      rd = (i % 3 == 0) ? 16'($urandom_range(1, 15)) : 16'($urandom_range(1, 65535));
      run_op(rn, rd, rn / rd, rn % rd, 1'b0, 0);
    end

    repeat (3) @(negedge Clk);
    check("sb_empty",      32'(sb.size()),   32'd0);
    check("busy_done_ovl", 32'(overlap_cnt), 32'd0);
    check("result_stable", 32'(unstable_cnt), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
